uart_tx: RTL



---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the uart_tx serialiser.
// The producer drives tx_data/tx_valid and the transmitter drives tx_ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity,
// then STOP_BITS stop bits. The bit period comes from an internal divider.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit).
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d;
    logic          tick;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign tick         = (cnt_q == CNT_MAX);
    // tx_ready comes straight from the state register, never from tx_valid.
    assign bus.tx_ready = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);

    // Next-state, divider, shift register and next line level.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    state_d  = S_START;
                    cnt_d    = '0;
                    bit_d    = '0;
                    stop_d   = 1'b0;
                    shift_d  = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        stop_d  = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so tx stays registered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces an idle, high line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
